crp16_mem_responder: RTL and testbench

Data-memory responder for the CRP16 core: services the processor's EX/MEM-stage load and store requests over a valid/ready request channel and a single-cycle response pulse. Adds configurable wait states, low-byte (read-modify-write) access and an out-of-range error. It sits between the core's data port and a private word-addressed synchronous RAM.

---
 rtl/crp16_mem_responder_pkg.sv | 16 +
 rtl/crp16_mem_array.sv | 28 ++
 rtl/crp16_mem_responder.sv | 142 ++++++++++++++
 tb/tb_crp16_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crp16_mem_responder_pkg.sv
// Shared definitions for the CRP16 data-memory responder: FSM state encodings,
// wait-counter width and the default RAM address width.
package crp16_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_MERGE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam int WAIT_CNT_BITS     = 4;
    localparam int DEFAULT_ADDR_BITS = 5;

endpackage

// File: rtl/crp16_mem_array.sv
// Private single-port word RAM for the CRP16 data responder: synchronous write,
// registered read, contents preloaded from the RAM init file (never reset).
module crp16_mem_array
    import crp16_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          q
);

    (* ram_init_file = "crp16_mem.mif" *)
    logic [15:0] mem [0:(2**ADDR_BITS)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/crp16_mem_responder.sv
// CRP16 EX/MEM data-port responder: wait states, word/byte loads and stores, range error.
// Byte access (MERGE state, sign/zero extension) is compiled in with CRP16_MEM_BYTE_EN.
module crp16_mem_responder
    import crp16_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_error
);

`ifdef CRP16_MEM_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    localparam logic [WAIT_CNT_BITS-1:0] CNT_LOAD =
        WAIT_CNT_BITS'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [WAIT_CNT_BITS-1:0] CNT_ONE = WAIT_CNT_BITS'(1);

    state_t                   state_reg, state_next;
    logic [WAIT_CNT_BITS-1:0] cnt_reg, cnt_next;
    logic                     write_reg, byte_reg, signed_reg, err_reg;
    logic [ADDR_BITS-1:0]     addr_reg;
    logic [15:0]              wdata_reg;

    logic        accept;
    logic        byte_acc, byte_store, word_store;
    logic        ram_we, ram_re;
    logic [15:0] ram_wdata, q, load_data;

    assign accept     = req_valid && (state_reg == ST_IDLE);
    // With byte support compiled out every request degrades to a word access.
    assign byte_acc   = BYTE_EN & byte_reg;
    assign byte_store = write_reg & byte_acc;
    assign word_store = write_reg & ~byte_acc;
    assign load_data  = byte_acc ? {{8{q[7] & signed_reg}}, q[7:0]} : q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            write_reg  <= 1'b0;
            byte_reg   <= 1'b0;
            signed_reg <= 1'b0;
            err_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg  <= req_write;
                byte_reg   <= req_byte;
                signed_reg <= req_signed;
                err_reg    <= (req_addr >> ADDR_BITS) != 16'd0;
                addr_reg   <= req_addr[ADDR_BITS-1:0];
                wdata_reg  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_wdata  = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                // Out-of-range requests walk the same states but never write.
                if (word_store) begin
                    ram_we     = ~err_reg;
                    state_next = ST_RESP;
                end else begin
                    ram_re     = 1'b1;
                    state_next = byte_store ? ST_MERGE : ST_RESP;
                end
            end
            ST_MERGE: begin
                ram_we     = ~err_reg;
                ram_wdata  = {q[15:8], wdata_reg[7:0]};
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_reg;
                resp_rdata = (write_reg || err_reg) ? 16'd0 : load_data;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    crp16_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_reg),
        .wdata (ram_wdata),
        .q     (q)
    );

endmodule

// File: tb/tb_crp16_mem_responder.sv
// Self-checking bench for crp16_mem_responder: a transaction-level model predicts
// acceptance, response cycle and data; directed cases pin the model with literals.
module tb_crp16_mem_responder;

    localparam int WS = 1;
    localparam int AB = 5;
`ifdef CRP16_MEM_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [15:0] resp_rdata;

    crp16_mem_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
        .clock      (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    initial forever #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    logic [15:0] mdl_mem [32];
    bit          pend = 1'b0;
    int          pend_resp_cyc = 0;
    int          acc_cyc = 0;
    int          acc_count = 0;
    logic [15:0] exp_rdata = '0;
    bit          exp_err = 1'b0;
    bit          pend_we = 1'b0;
    logic [4:0]  pend_wa = '0;
    logic [15:0] pend_wd = '0;

    function automatic logic [15:0] exp_load(logic [15:0] old, logic b, logic s);
        if (BYTE_EN && b) return (s && old[7]) ? {8'hFF, old[7:0]} : {8'h00, old[7:0]};
        return old;
    endfunction

    function automatic logic [15:0] exp_store(logic [15:0] old, logic [15:0] wd, logic b);
        return (BYTE_EN && b) ? {old[15:8], wd[7:0]} : wd;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= 1'b0;
        end else begin
            if (pend && cyc == pend_resp_cyc) begin
                pend <= 1'b0;
                if (pend_we) mdl_mem[pend_wa] <= pend_wd;
            end
            if (!pend && req_valid) begin
                pend          <= 1'b1;
                acc_cyc       <= cyc + 1;
                acc_count     <= acc_count + 1;
                pend_resp_cyc <= cyc + 2 + WS + ((BYTE_EN && req_byte && req_write) ? 1 : 0);
                exp_err       <= !(req_addr < 16'd32);
                exp_rdata     <= (!(req_addr < 16'd32) || req_write) ? 16'd0
                                 : exp_load(mdl_mem[req_addr[4:0]], req_byte, req_signed);
                pend_we       <= (req_addr < 16'd32) && req_write;
                pend_wa       <= req_addr[4:0];
                pend_wd       <= exp_store(mdl_mem[req_addr[4:0]], req_wdata, req_byte);
            end
        end
    end

    // ---------------- checking ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] obs_rdata = '0;
    logic        obs_err = 1'b0;
    int          obs_lat = 0, obs_cyc = 0, obs_prev_cyc = 0, resp_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("reset_req_ready", req_ready, 1);
                chk("reset_resp_valid", resp_valid, 0);
                chk("reset_resp_rdata", resp_rdata, 0);
                chk("reset_resp_error", resp_error, 0);
            end else begin
                chk("req_ready", req_ready, !pend);
                chk("resp_valid", resp_valid, pend && (cyc == pend_resp_cyc));
                if (pend && cyc == pend_resp_cyc) begin
                    chk("resp_rdata", resp_rdata, exp_rdata);
                    chk("resp_error", resp_error, exp_err);
                end
                if (resp_valid) begin
                    obs_rdata    = resp_rdata;
                    obs_err      = resp_error;
                    obs_lat      = cyc - acc_cyc;
                    obs_prev_cyc = obs_cyc;
                    obs_cyc      = cyc;
                    resp_count++;
                    $display("resp cycle %0d: rdata=%h error=%b latency=%0d",
                             cyc, resp_rdata, resp_error, obs_lat);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance, req_valid still high.
    task automatic issue(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] d);
        int start;
        int n;
        req_write  = w;
        req_byte   = b;
        req_signed = s;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        start      = acc_count;
        n          = 0;
        while (acc_count == start && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_budget", acc_count != start, 1);
    endtask

    task automatic wait_idle();
        int n;
        req_valid = 1'b0;
        n = 0;
        while (pend && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", pend, 0);
    endtask

    logic [15:0] init0;
    int          cnt0;

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);

        // Preload every word so the model knows the whole RAM.
        init0 = 16'($urandom);
        for (int i = 0; i < 32; i++) begin
            logic [15:0] v;
            v = (i == 0) ? init0 : (i == 3) ? 16'hA5C3 : (i == 5) ? 16'h0F05 : 16'($urandom);
            issue(1'b1, 1'b0, 1'b0, 16'(i), v);
        end
        wait_idle();

        issue(1'b0, 1'b0, 1'b0, 16'd3, 16'h0);
        wait_idle();
        chk("word_load_rdata", obs_rdata, 16'hA5C3);
        chk("word_load_error", obs_err, 0);
        chk("word_load_latency", obs_lat, 2);

        issue(1'b0, 1'b1, 1'b1, 16'd3, 16'h0);
        wait_idle();
        chk("byte_load_signed", obs_rdata, BYTE_EN ? 16'hFFC3 : 16'hA5C3);
        chk("byte_load_latency", obs_lat, 2);

        issue(1'b0, 1'b1, 1'b0, 16'd3, 16'h0);
        wait_idle();
        chk("byte_load_unsigned", obs_rdata, BYTE_EN ? 16'h00C3 : 16'hA5C3);

        issue(1'b1, 1'b1, 1'b0, 16'd3, 16'h1234);
        wait_idle();
        chk("byte_store_latency", obs_lat, BYTE_EN ? 3 : 2);
        chk("byte_store_rdata", obs_rdata, 16'h0000);
        issue(1'b0, 1'b0, 1'b0, 16'd3, 16'h0);
        wait_idle();
        chk("byte_store_readback", obs_rdata, BYTE_EN ? 16'hA534 : 16'h1234);

        issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF);
        wait_idle();
        chk("range_error_flag", obs_err, 1);
        chk("range_error_rdata", obs_rdata, 16'h0000);
        issue(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
        wait_idle();
        chk("range_error_mem0", obs_rdata, init0);

        // Second request held on req_valid while the first is in flight.
        cnt0 = resp_count;
        issue(1'b0, 1'b0, 1'b0, 16'd7, 16'h0);
        issue(1'b0, 1'b0, 1'b0, 16'd8, 16'h0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_pulse_count", resp_count - cnt0, 2);
        chk("held_pulse_spacing", obs_cyc - obs_prev_cyc, WS + 3);

        // Reset during WAIT of a word store to addr 5 aborts the write.
        issue(1'b1, 1'b0, 1'b0, 16'd5, 16'h7777);
        req_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("async_reset_ready", req_ready, 1);
        chk("async_reset_valid", resp_valid, 0);
        cnt0 = resp_count;
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b0, 16'd5, 16'h0);
        wait_idle();
        chk("reset_abort_pulses", resp_count - cnt0, 1);
        chk("reset_abort_mem5", obs_rdata, 16'h0F05);
        chk("post_reset_latency", obs_lat, 2);

        // Randomised traffic with random gaps (gap 0 keeps req_valid held).
        for (int t = 0; t < 150; t++) begin
            logic [15:0] a;
            int          gap;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32, 65535))
                                            : 16'($urandom_range(0, 31));
            issue(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                req_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
